// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler:
// road indexing, phase encoding and a road one-hot helper.
package traffic_pkg;

    localparam int ROAD_W    = 2;
    localparam int NUM_ROADS = 4;

    localparam logic [1:0] PH_ALLRED = 2'd0;
    localparam logic [1:0] PH_GREEN  = 2'd1;
    localparam logic [1:0] PH_YELLOW = 2'd2;

    function automatic logic [NUM_ROADS-1:0] road_oh(
        input logic [ROAD_W-1:0] r
    );
        road_oh    = '0;
        road_oh[r] = 1'b1;
    endfunction

endpackage

// File: rtl/traffic_rr_picker.sv
// Combinational 4-way round-robin road picker.
// Ports: req (demand), last_road, emerg_valid/emerg_road (override)
//        -> next_road.
module traffic_rr_picker
    import traffic_pkg::*;
(
    input  logic [NUM_ROADS-1:0] req,
    input  logic [ROAD_W-1:0]    last_road,
    input  logic                 emerg_valid,
    input  logic [ROAD_W-1:0]    emerg_road,
    output logic [ROAD_W-1:0]    next_road
);

    logic [ROAD_W-1:0] cand;
    logic              found;

    always_comb begin
        next_road = last_road + ROAD_W'(1);
        cand      = '0;
        found     = 1'b0;
        if (emerg_valid) begin
            next_road = emerg_road;
        end else begin
            // Scan last+1 .. last+4; the index wraps modulo the road count.
            for (int k = 1; k <= NUM_ROADS; k++) begin
                cand = last_road + ROAD_W'(k);
                if (!found && req[cand]) begin
                    next_road = cand;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated GREEN/YELLOW/ALL_RED scheduler for a 4-road crossing.
// Ports: clk, reset (async, high), tick strobe, req[3:0], emerg_valid,
//        emerg_road -> registered lamp_red/yellow/green, active_road, phase.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int GREEN_MIN    = 5,
    parameter int GREEN_MAX    = 20,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [NUM_ROADS-1:0] req,
    input  logic                 emerg_valid,
    input  logic [ROAD_W-1:0]    emerg_road,
    output logic [NUM_ROADS-1:0] lamp_red,
    output logic [NUM_ROADS-1:0] lamp_yellow,
    output logic [NUM_ROADS-1:0] lamp_green,
    output logic [ROAD_W-1:0]    active_road,
    output logic [1:0]           phase
);

    typedef enum logic [1:0] {
        ST_ALLRED = PH_ALLRED,
        ST_GREEN  = PH_GREEN,
        ST_YELLOW = PH_YELLOW
    } state_t;

    localparam logic [CNT_W:0]   G_MIN  = GREEN_MIN[CNT_W:0];
    localparam logic [CNT_W:0]   G_MAX  = GREEN_MAX[CNT_W:0];
    localparam logic [CNT_W-1:0] G_SAT  = GREEN_MAX[CNT_W-1:0];
    localparam logic [CNT_W-1:0] Y_LOAD = YELLOW_TICKS[CNT_W-1:0];
    localparam logic [CNT_W-1:0] R_LOAD = ALLRED_TICKS[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  elapsed;
    logic [CNT_W:0]    elapsed_inc;
    logic [CNT_W-1:0]  elapsed_nxt;
    logic [ROAD_W-1:0] pick;
    logic              other_req;
    logic              go_yellow;

    traffic_rr_picker u_pick (
        .req         (req),
        .last_road   (active_road),
        .emerg_valid (emerg_valid),
        .emerg_road  (emerg_road),
        .next_road   (pick)
    );

    // Extra bit so the +1 compare cannot wrap before saturation.
    assign elapsed_inc = {1'b0, elapsed} + {{CNT_W{1'b0}}, 1'b1};
    assign elapsed_nxt = (elapsed_inc >= G_MAX) ? G_SAT
                                                : elapsed_inc[CNT_W-1:0];
    assign other_req   = |(req & ~road_oh(active_road));

    // An emergency for the active road pins green; one for another road
    // cuts green short regardless of the minimum.
    always_comb begin
        go_yellow = 1'b0;
        if (emerg_valid) begin
            go_yellow = (emerg_road != active_road);
        end else begin
            go_yellow = (elapsed_inc >= G_MIN) && other_req &&
                        (!req[active_road] || (elapsed_inc >= G_MAX));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_ALLRED;
            active_road <= '1;
            timer       <= R_LOAD;
            elapsed     <= '0;
            lamp_red    <= '1;
            lamp_yellow <= '0;
            lamp_green  <= '0;
        end else if (tick) begin
            unique case (state)
                ST_ALLRED: begin
                    if (timer == ONE) begin
                        state       <= ST_GREEN;
                        active_road <= pick;
                        elapsed     <= '0;
                        lamp_red    <= ~road_oh(pick);
                        lamp_green  <= road_oh(pick);
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                ST_GREEN: begin
                    if (go_yellow) begin
                        state       <= ST_YELLOW;
                        timer       <= Y_LOAD;
                        lamp_green  <= '0;
                        lamp_yellow <= road_oh(active_road);
                    end else begin
                        elapsed <= elapsed_nxt;
                    end
                end
                ST_YELLOW: begin
                    if (timer == ONE) begin
                        state       <= ST_ALLRED;
                        timer       <= R_LOAD;
                        lamp_yellow <= '0;
                        lamp_red    <= '1;
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                default: begin
                    state       <= ST_ALLRED;
                    timer       <= R_LOAD;
                    lamp_red    <= '1;
                    lamp_yellow <= '0;
                    lamp_green  <= '0;
                end
            endcase
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios
// plus random req/emergency/tick traffic against a tick-counting model.
module tb_traffic_phase_scheduler;

    localparam int GMIN = 3;
    localparam int GMAX = 6;
    localparam int YT   = 2;
    localparam int RT   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] req;
    logic       emerg_valid;
    logic [1:0] emerg_road;
    logic [3:0] lamp_red, lamp_yellow, lamp_green;
    logic [1:0] active_road, phase;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0=all-red 1=green 2=yellow, ticks spent so far.
    int   m_ph;
    int   m_road;
    int   m_cnt;
    int   ycnt;
    logic [3:0] lit_acc;

    traffic_phase_scheduler #(
        .CNT_W        (8),
        .GREEN_MIN    (GMIN),
        .GREEN_MAX    (GMAX),
        .YELLOW_TICKS (YT),
        .ALLRED_TICKS (RT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .req         (req),
        .emerg_valid (emerg_valid),
        .emerg_road  (emerg_road),
        .lamp_red    (lamp_red),
        .lamp_yellow (lamp_yellow),
        .lamp_green  (lamp_green),
        .active_road (active_road),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_road();
        if (emerg_valid) return int'(emerg_road);
        for (int k = 1; k <= 4; k++)
            if (req[(m_road + k) % 4]) return (m_road + k) % 4;
        return (m_road + 1) % 4;
    endfunction

    task automatic model_update();
        bit others;
        bit leave;
        if (!tick) return;
        m_cnt++;
        case (m_ph)
            0: if (m_cnt >= RT) begin
                m_road = pick_road();
                m_ph   = 1;
                m_cnt  = 0;
            end
            1: begin
                others = (req & ~(4'b0001 << m_road)) != 4'b0000;
                if (emerg_valid)
                    leave = (int'(emerg_road) != m_road);
                else
                    leave = (m_cnt >= GMIN) && others &&
                            (!req[m_road] || m_cnt >= GMAX);
                if (leave) begin
                    m_ph  = 2;
                    m_cnt = 0;
                end
            end
            default: if (m_cnt >= YT) begin
                m_ph  = 0;
                m_cnt = 0;
            end
        endcase
    endtask

    task automatic step(input logic t);
        logic [1:0] pre;
        logic [3:0] oh, er, ey, eg;
        bit ok;
        int nonred;
        pre  = phase;
        tick = t;
        if (pre == 2'd2 && t) ycnt++;
        @(posedge clk);
        model_update();
        @(negedge clk);
        oh = 4'b0001 << m_road;
        er = (m_ph == 0) ? 4'hF : ~oh;
        ey = (m_ph == 2) ? oh : 4'h0;
        eg = (m_ph == 1) ? oh : 4'h0;
        check("lamps", {lamp_red, lamp_yellow, lamp_green}, {er, ey, eg});
        check("phase_road", {phase, active_road}, {m_ph[1:0], m_road[1:0]});
        ok = 1'b1;
        nonred = 0;
        for (int i = 0; i < 4; i++) begin
            if (int'(lamp_red[i]) + int'(lamp_yellow[i]) +
                int'(lamp_green[i]) != 1) ok = 1'b0;
            if (!lamp_red[i]) nonred++;
        end
        if (nonred > 1) ok = 1'b0;
        check("invariant", {31'd0, ok}, 32'd1);
        if (pre == 2'd2 && phase != 2'd2) check("yellow_len", ycnt, YT);
        if (pre != 2'd2 && phase == 2'd2) ycnt = 0;
        lit_acc |= ~lamp_red;
        tick = 1'b0;
    endtask

    task automatic tick_once();
        repeat (3) step(1'b0);
        step(1'b1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_red", lamp_red, 4'hF);
        check("rst_yg", {lamp_yellow, lamp_green}, 8'h00);
        check("rst_ph", {phase, active_road}, {2'd0, 2'd3});
        m_ph   = 0;
        m_road = 3;
        m_cnt  = 0;
        ycnt   = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        tick        = 1'b0;
        req         = 4'b0000;
        emerg_valid = 1'b0;
        emerg_road  = 2'd0;
        lit_acc     = 4'h0;
        @(negedge clk);

        // Serve road 2, then reset in the middle of its green.
        do_reset();
        tick_once();
        check("t1_g0", lamp_green, 4'b0001);
        req = 4'b0100;
        ticks(3);
        check("t1_y0", lamp_yellow, 4'b0001);
        ticks(3);
        check("t1_g2", lamp_green, 4'b0100);
        ticks(2);
        do_reset();
        req = 4'b0000;
        tick_once();
        check("t1_after", lamp_green, 4'b0001);

        // No demand: road 0 rests in green.
        do_reset();
        ticks(21);
        check("t2_rest", {phase, lamp_green}, {2'd1, 4'b0001});

        // Only roads 1 and 3 demand; 0 and 2 never lit.
        do_reset();
        req     = 4'b1010;
        lit_acc = 4'h0;
        tick_once();
        check("t3_g1", lamp_green, 4'b0010);
        ticks(5);
        check("t3_g1_hold", lamp_green, 4'b0010);
        tick_once();
        check("t3_y1", lamp_yellow, 4'b0010);
        ticks(3);
        check("t3_g3", lamp_green, 4'b1000);
        ticks(9);
        check("t3_back1", lamp_green, 4'b0010);
        check("t3_unlit", lit_acc & 4'b0101, 4'b0000);

        // Both roads 0 and 1 waiting: green 0 runs to maximum.
        do_reset();
        req = 4'b0011;
        tick_once();
        check("t4_g0", lamp_green, 4'b0001);
        ticks(5);
        check("t4_hold", lamp_green, 4'b0001);
        tick_once();
        check("t4_y0", lamp_yellow, 4'b0001);
        ticks(3);
        check("t4_g1", lamp_green, 4'b0010);

        // Emergency for road 2 pre-empts green 0 at elapsed=1.
        do_reset();
        req = 4'b0000;
        ticks(2);
        emerg_valid = 1'b1;
        emerg_road  = 2'd2;
        tick_once();
        check("t5_y0", lamp_yellow, 4'b0001);
        tick_once();
        check("t5_y0b", lamp_yellow, 4'b0001);
        tick_once();
        check("t5_red", lamp_red, 4'hF);
        tick_once();
        check("t5_g2", lamp_green, 4'b0100);
        req = 4'b1111;
        ticks(8);
        check("t5_hold", lamp_green, 4'b0100);
        emerg_valid = 1'b0;

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                emerg_valid = ~emerg_valid;
                emerg_road  = 2'($urandom);
            end
            step($urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
